ccff_stream_loader: RTL and testbench
=====================================

# ccff_stream_loader

Configuration-chain loader that sits directly upstream of the grid tiles' `ccff_head` input and downstream of the bitstream source. It accepts configuration words over a valid/ready interface and serializes them onto the configuration flip-flop chain. It generates the per-cycle shift enable used to gate `prog_clk` to the fabric. It verifies chain integrity by pushing a known signature through the chain and checking it at `ccff_tail`.

## Interface
Parameters:
- `WORD_W`, default 8: width of one configuration word.
- `CHAIN_LEN`, default 1024: number of flip-flops in the chain between `ccff_head` and `ccff_tail`; must be ≥ 1.
- `SIG_W`, default 8: signature length in bits.
- `SIG`, default 8'hA5: signature value; `SIG_W` bits wide.

Ports (name, direction, width, meaning):
- `prog_clk`, in, 1: the block's only clock.
- `prog_reset`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle pulse that begins a load; ignored while `busy`=1.
- `cfg_valid`, in, 1: configuration word on `cfg_data` is valid.
- `cfg_ready`, out, 1: the block accepts the word on this cycle; transfer occurs when `cfg_valid` & `cfg_ready`.
- `cfg_data`, in, `WORD_W`: configuration word; bit 0 is shifted first.
- `ccff_head`, out, 1: serial data into the chain. Registered.
- `chain_clk_en`, out, 1: the chain captures `ccff_head` at the rising edge ending this cycle. Drives an external clock gate on the fabric's `prog_clk`. Registered.
- `ccff_tail`, in, 1: output of the last flip-flop in the chain.
- `busy`, out, 1: a load is in progress.
- `done`, out, 1: the last load completed. Held until the next accepted `start`.
- `sig_err`, out, 1: the signature check failed. Valid while `done`=1 and held with it.

## Operation
- State machine with states IDLE, SIG, DATA, FIN.
- IDLE
  - Outputs: `busy`=0, `chain_clk_en`=0, `cfg_ready`=0.
  - On `start`: clear `done`, `sig_err`, the shift counter k, and the word buffer; go to SIG.
- SIG
  - Shifts `SIG` MSB first, one bit per cycle, with `chain_clk_en`=1.
  - Never stalls; runs exactly `SIG_W` cycles, then goes to DATA.
- DATA
  - Shifts `CHAIN_LEN` configuration bits from the word buffer, LSB first.
  - `chain_clk_en`=1 only in cycles where the buffer holds a bit. Otherwise `chain_clk_en`=0 and `ccff_head` holds its previous value.
- Word fetch
  - `cfg_ready`=1 in SIG or DATA when both hold:
    - the buffer is empty, or its last remaining bit shifts this cycle;
    - at least one configuration bit remains unfetched.
  - A word accepted on cycle t supplies its first bit to the chain on cycle t+1. A held-high `cfg_valid` therefore gives gap-free shifting.
  - The first word may be fetched during SIG.
- Last word
  - Words fetched = ceil(`CHAIN_LEN`/`WORD_W`).
  - In the last word, only the low (`CHAIN_LEN` mod `WORD_W`, or `WORD_W` if 0) bits are shifted. The rest are discarded.
- Signature check
  - k counts enabled shifts, 0 to `SIG_W`+`CHAIN_LEN`−1.
  - On each enabled shift with k ≥ `CHAIN_LEN`, sample `ccff_tail` and compare it with signature bit (`SIG_W`−1−(k−`CHAIN_LEN`)).
  - Any mismatch sets a sticky error flag.
  - After the load, the signature has left the chain, and the chain holds exactly the configuration bits.
- FIN: reached after shift `SIG_W`+`CHAIN_LEN`−1. Lasts one cycle, sets `done`=1 and `sig_err`=flag, then returns to IDLE.
- Counter widths: k is ceil(log2(`SIG_W`+`CHAIN_LEN`+1)) bits. There is no wrap-around within a load.

## Timing
- Reset values: `cfg_ready`=0, `ccff_head`=0, `chain_clk_en`=0, `busy`=0, `done`=0, `sig_err`=0. State is IDLE.
- Reset mid-operation aborts immediately. Chain contents are undefined, and a new `start` is required.
- Start timing: `start` is sampled on cycle t. `busy`=1 and `chain_clk_en`=1 with SIG bit (`SIG_W`−1) on `ccff_head` from cycle t+1.
- Minimum load latency with no stalls: `start` to `done` rising is `SIG_W`+`CHAIN_LEN`+1 cycles. `busy` falls in the same cycle that `done` rises.
- Stalls (`cfg_valid`=0 when a word is needed) extend DATA one cycle per stall cycle. The total count of `chain_clk_en`=1 cycles is always exactly `SIG_W`+`CHAIN_LEN`.
- `cfg_ready` does not depend combinationally on `cfg_valid`.
- `start` in the same cycle as FIN is ignored.

## Test plan
Scenarios 1–4 use `WORD_W`=8, `CHAIN_LEN`=20, `SIG`=8'hA5. The bench models the chain as a 20-bit shift register clocked when `chain_clk_en`=1.
1. Reset release with no stimulus -> all outputs 0 for 10 cycles, and `cfg_ready` never asserts.
2. `start`, `cfg_valid` held high with words 0x3C, 0xF0, 0x0A -> exactly 3 handshakes; 28 contiguous `chain_clk_en` cycles; `ccff_head` sequence is 1,0,1,0,0,1,0,1 then 0x3C LSB first, 0xF0 LSB first, and 0,1,0,1; chain model equals those 20 bits; `done`=1 on cycle 30 after `start`; `sig_err`=0.
3. Same data as scenario 2, with `cfg_valid` dropped for 5 cycles before the second word -> `chain_clk_en`=0 for exactly 5 cycles with `ccff_head` stable; 28 enables in total; `done` on cycle 35; `sig_err`=0.
4. Chain model with `ccff_tail` stuck at 0 -> `done`=1 and `sig_err`=1; a second `start` clears both within 1 cycle.
5. `start` pulsed during DATA -> ignored; the load completes normally. Then a fresh load with `prog_reset` asserted mid-DATA -> all outputs 0 next cycle; a new `start` restarts at SIG with head bit 1.

Source files
------------

// File: rtl/ccff_stream_loader_if.sv
// Configuration word handshake between the bitstream source and the chain loader.
// Latency: none, wires only.
// Backpressure: the loader raises cfg_ready only when it can take a word; transfer on cfg_valid & cfg_ready.
interface ccff_stream_loader_if #(
    parameter int WORD_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_stream_loader.sv
// Serializes a signature then configuration words onto the ccff chain and checks the signature at ccff_tail.
// Latency: start to done is SIG_W+CHAIN_LEN+1 cycles when cfg_valid never stalls a needed word.
// Backpressure: an empty word buffer with no accepted word pauses shifting (chain_clk_en=0, ccff_head held).
module ccff_stream_loader #(
    parameter int               WORD_W    = 8,
    parameter int               CHAIN_LEN = 1024,
    parameter int               SIG_W     = 8,
    parameter logic [SIG_W-1:0] SIG       = 8'hA5
) (
    input  logic                 prog_clk,
    input  logic                 prog_reset,
    input  logic                 start,
    ccff_stream_loader_if.slave  cfg,
    output logic                 ccff_head,
    output logic                 chain_clk_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 sig_err
);

    localparam int TOTAL  = SIG_W + CHAIN_LEN;
    localparam int KW     = $clog2(TOTAL + 1);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int NW     = $clog2(NWORDS + 1);
    localparam int CW     = $clog2(WORD_W + 1);

    localparam logic [KW-1:0] K_LAST     = KW'(TOTAL - 1);
    localparam logic [KW-1:0] K_SIG_LAST = KW'(SIG_W - 1);
    localparam logic [KW-1:0] K_CHAIN    = KW'(CHAIN_LEN);
    localparam logic [CW-1:0] C_FULL     = CW'(WORD_W);
    localparam logic [CW-1:0] C_LAST     = CW'(CHAIN_LEN - (NWORDS - 1) * WORD_W);
    localparam logic [NW-1:0] W_ALL      = NW'(NWORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SIG  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]        state;
    // Number of enabled shifts already completed; equals the index of the shift on ccff_head when chain_clk_en=1.
    logic [KW-1:0]     k;
    // Bits of the current word that have not yet been placed on ccff_head, LSB next.
    logic [WORD_W-1:0] buf_dat;
    logic [CW-1:0]     buf_cnt;
    logic [NW-1:0]     words_left;
    logic              err_flag;

    logic              fetch;
    logic              tail_bad;
    logic [CW-1:0]     fetch_cnt;
    logic [SIG_W-1:0]  sig_tail_sh;
    logic [SIG_W-1:0]  sig_next_sh;

    // A word is wanted once the buffer has nothing left beyond the bit now shifting; never looks at cfg_valid.
    assign cfg.cfg_ready = ((state == S_SIG) || (state == S_DATA)) && (buf_cnt == '0) && (words_left != '0);
    assign fetch         = cfg.cfg_valid && cfg.cfg_ready;
    // The final word only carries the bits that still fit in the chain.
    assign fetch_cnt     = (words_left == NW'(1)) ? C_LAST : C_FULL;
    // Shift k >= CHAIN_LEN sees signature bit SIG_W-1-(k-CHAIN_LEN) = TOTAL-1-k at the tail.
    assign sig_tail_sh   = SIG >> (K_LAST - k);
    assign sig_next_sh   = SIG << (k + KW'(1));
    assign tail_bad      = chain_clk_en && (k >= K_CHAIN) && (ccff_tail != sig_tail_sh[0]);

    // Load sequencing: each edge decides what the chain shifts in the following cycle.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state        <= S_IDLE;
            k            <= '0;
            buf_dat      <= '0;
            buf_cnt      <= '0;
            words_left   <= '0;
            err_flag     <= 1'b0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sig_err      <= 1'b0;
        end else begin
            if (chain_clk_en) begin
                k <= k + KW'(1);
            end
            if (tail_bad) begin
                err_flag <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    chain_clk_en <= 1'b0;
                    if (start) begin
                        state        <= S_SIG;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        sig_err      <= 1'b0;
                        err_flag     <= 1'b0;
                        k            <= '0;
                        buf_dat      <= '0;
                        buf_cnt      <= '0;
                        words_left   <= W_ALL;
                        ccff_head    <= SIG[SIG_W-1];
                        chain_clk_en <= 1'b1;
                    end
                end
                S_SIG, S_DATA: begin
                    if (chain_clk_en && (k == K_LAST)) begin
                        state        <= S_FIN;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        sig_err      <= err_flag | tail_bad;
                        chain_clk_en <= 1'b0;
                    end else if ((state == S_SIG) && (k != K_SIG_LAST)) begin
                        // Signature phase never stalls; an early word is parked whole in the buffer.
                        ccff_head    <= sig_next_sh[SIG_W-1];
                        chain_clk_en <= 1'b1;
                        if (fetch) begin
                            buf_dat    <= cfg.cfg_data;
                            buf_cnt    <= fetch_cnt;
                            words_left <= words_left - NW'(1);
                        end
                    end else begin
                        state <= S_DATA;
                        if (buf_cnt != '0) begin
                            ccff_head    <= buf_dat[0];
                            buf_dat      <= buf_dat >> 1;
                            buf_cnt      <= buf_cnt - CW'(1);
                            chain_clk_en <= 1'b1;
                        end else if (fetch) begin
                            // A word accepted now goes straight to the head so held-high valid gives no gaps.
                            ccff_head    <= cfg.cfg_data[0];
                            buf_dat      <= cfg.cfg_data >> 1;
                            buf_cnt      <= fetch_cnt - CW'(1);
                            words_left   <= words_left - NW'(1);
                            chain_clk_en <= 1'b1;
                        end else begin
                            chain_clk_en <= 1'b0;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Directed bench for ccff_stream_loader with a 20-flop chain model and an expected head-bit stream.
// Latency: checks done timing against hand-computed cycle numbers.
// Backpressure: a source process can withhold cfg_valid for a set number of wanted cycles.
module tb_ccff_stream_loader;

    localparam int         WORD_W    = 8;
    localparam int         CHAIN_LEN = 20;
    localparam int         SIG_W     = 8;
    localparam logic [7:0] SIG_V     = 8'hA5;
    localparam int         TOTAL     = SIG_W + CHAIN_LEN;

    logic prog_clk   = 1'b0;
    logic prog_reset = 1'b0;
    logic start      = 1'b0;
    logic ccff_head;
    logic chain_clk_en;
    logic ccff_tail;
    logic busy;
    logic done;
    logic sig_err;

    ccff_stream_loader_if #(.WORD_W(WORD_W)) cfg ();

    ccff_stream_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .SIG_W    (SIG_W),
        .SIG      (SIG_V)
    ) dut (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .start       (start),
        .cfg         (cfg),
        .ccff_head   (ccff_head),
        .chain_clk_en(chain_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .sig_err     (sig_err)
    );

    always #5 prog_clk = ~prog_clk;

    int          total     = 0;
    int          passed    = 0;
    bit          exp_q[$];
    logic [7:0]  word_q[$];
    logic [19:0] chain     = '0;
    logic        stuck     = 1'b0;
    logic        pend      = 1'b0;
    logic        pend_bit  = 1'b0;
    logic        prev_head = 1'b0;
    bit          mon       = 1'b0;
    int          en_cnt    = 0;
    int          stall_cnt = 0;
    int          hs_cnt    = 0;
    int          gap_left  = 0;
    logic [27:0] seen      = '0;

    // Configuration words 0x3C, 0xF0, 0x0A packed with word 0 in the low byte.
    localparam logic [23:0] ALL_BITS = {8'h0A, 8'hF0, 8'h3C};

    assign ccff_tail = stuck ? 1'b0 : chain[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Chain model: captures the head bit observed during an enabled cycle at the edge ending it.
    always @(posedge prog_clk) begin
        if (pend) chain <= {chain[18:0], pend_bit};
    end

    // Word source: presents the head of word_q, optionally withholding the second word.
    always @(posedge prog_clk) begin
        #1;
        cfg.cfg_valid = (word_q.size() > 0) && !(hs_cnt == 1 && gap_left > 0);
        cfg.cfg_data  = (word_q.size() > 0) ? word_q[0] : 8'h00;
    end

    // Per-cycle compare against the expected bit stream.
    always @(negedge prog_clk) begin
        bit e;
        pend = 1'b0;
        if (prog_reset) begin
            pend     = chain_clk_en;
            pend_bit = ccff_head;
            if (!cfg.cfg_valid && cfg.cfg_ready && hs_cnt == 1 && gap_left > 0) gap_left--;
            if (cfg.cfg_valid && cfg.cfg_ready) begin
                hs_cnt++;
                if (word_q.size() > 0) void'(word_q.pop_front());
            end
            if (mon) begin
                if (chain_clk_en) begin
                    en_cnt++;
                    seen = {seen[26:0], ccff_head};
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL extra_shift: enable seen with no expected bit left, head=%0b", ccff_head);
                    end else begin
                        e = exp_q.pop_front();
                        check("head_bit", 32'(ccff_head), 32'(e));
                    end
                end else if (busy) begin
                    stall_cnt++;
                    check("head_hold", 32'(ccff_head), 32'(prev_head));
                end
                if (!busy) check("idle_quiet", 32'({cfg.cfg_ready, chain_clk_en}), 32'(2'b00));
            end
            prev_head = ccff_head;
        end
    end

    task automatic load_setup(input int gap);
        logic [23:0] tmp;
        word_q.delete();
        word_q.push_back(8'h3C);
        word_q.push_back(8'hF0);
        word_q.push_back(8'h0A);
        gap_left  = gap;
        hs_cnt    = 0;
        en_cnt    = 0;
        stall_cnt = 0;
        seen      = '0;
        exp_q.delete();
        for (int i = SIG_W - 1; i >= 0; i--) begin
            tmp = 24'(SIG_V) >> i;
            exp_q.push_back(tmp[0]);
        end
        for (int i = 0; i < CHAIN_LEN; i++) begin
            tmp = ALL_BITS >> i;
            exp_q.push_back(tmp[0]);
        end
        mon = 1'b1;
    endtask

    task automatic run_load(input string tag, input int exp_cycle, input int exp_stall,
                            input logic exp_err, input int glitch_at, input bit fin_start);
        int n;
        bit got_done;
        n        = 0;
        got_done = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            @(negedge prog_clk);
            n++;
            if (n == 1)
                check({tag, "_first_cycle"}, 32'({done, sig_err, busy, chain_clk_en, ccff_head}), 32'(5'b00111));
            if (glitch_at > 0 && n == glitch_at) start = 1'b1;
            if (glitch_at > 0 && n == glitch_at + 1) start = 1'b0;
            if (done) got_done = 1'b1;
        end
        check({tag, "_done_cycle"}, 32'(n + 1), 32'(exp_cycle));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        check({tag, "_sig_err"}, 32'(sig_err), 32'(exp_err));
        check({tag, "_enables"}, 32'(en_cnt), 32'(TOTAL));
        check({tag, "_handshakes"}, 32'(hs_cnt), 32'(3));
        check({tag, "_stalls"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_bits_left"}, 32'(exp_q.size()), 32'(0));
        check({tag, "_head_stream"}, 32'(seen), 32'(28'hA53C0F5));
        check({tag, "_chain"}, 32'(chain), 32'(20'h3C0F5));
        if (fin_start) begin
            start = 1'b1;
            @(posedge prog_clk);
            #1;
            start = 1'b0;
            @(negedge prog_clk);
            check({tag, "_fin_start_ignored"}, 32'({busy, done}), 32'(2'b01));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
        $fatal(1);
    end

    initial begin
        // Reset values, then ten quiet cycles with no stimulus.
        repeat (3) @(negedge prog_clk);
        check("reset_values", 32'({cfg.cfg_ready, ccff_head, chain_clk_en, busy, done, sig_err}), 32'(0));
        prog_reset = 1'b1;
        mon        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge prog_clk);
            check("idle_after_reset", 32'({cfg.cfg_ready, ccff_head, chain_clk_en, busy, done, sig_err}), 32'(0));
        end
        tick();

        // Gap-free load; a start during the FIN cycle must not begin a new load.
        load_setup(0);
        run_load("nostall", 30, 0, 1'b0, 0, 1'b1);

        // Five wanted cycles with cfg_valid low before the second word.
        load_setup(5);
        run_load("stall5", 35, 5, 1'b0, 0, 1'b0);

        // Tail stuck low breaks the signature; the next start clears done/sig_err.
        stuck = 1'b1;
        load_setup(0);
        run_load("stuck", 30, 0, 1'b1, 0, 1'b0);
        stuck = 1'b0;
        load_setup(0);
        run_load("after_stuck", 30, 0, 1'b0, 0, 1'b0);

        // Start pulsed mid-DATA is ignored.
        load_setup(0);
        run_load("start_in_data", 30, 0, 1'b0, 12, 1'b0);

        // Reset in the middle of DATA, then a clean restart.
        load_setup(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) @(negedge prog_clk);
        prog_reset = 1'b0;
        @(negedge prog_clk);
        check("reset_mid_data", 32'({cfg.cfg_ready, ccff_head, chain_clk_en, busy, done, sig_err}), 32'(0));
        prog_reset = 1'b1;
        mon = 1'b0;
        exp_q.delete();
        word_q.delete();
        tick();
        load_setup(0);
        run_load("after_reset", 30, 0, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
